// File: rtl/alarm_btn_pkg.sv
// Shared types and helpers for the alarm/snooze button conditioner.
package alarm_btn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DEB_PRS = 3'd1,
    ST_PRESSED = 3'd2,
    ST_HELD    = 3'd3,
    ST_DEB_REL = 3'd4
  } btn_state_t;

  localparam logic [1:0] EV_NONE   = 2'b00;
  localparam logic [1:0] EV_SHORT  = 2'b01;
  localparam logic [1:0] EV_LONG   = 2'b10;
  localparam logic [1:0] EV_REPEAT = 2'b11;

  function automatic int unsigned ms_to_cycles(input int unsigned hz, input int unsigned ms);
    return (hz / 32'd1000) * ms;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_sync2.sv
// Two-flop synchroniser for an asynchronous pad input; both flops reset to RST_VAL.
module btn_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/alarm_button_conditioner.sv
// Alarm/snooze button conditioner: sync, debounce, short/long press, sticky irq.
// Optional auto-repeat while held is enabled by defining AUTO_REPEAT_EN.
module alarm_button_conditioner
  import alarm_btn_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned REPEAT_MS   = 200,
  parameter int unsigned ACTIVE_LOW  = 1
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       button_in,
  input  logic       irq_ack,
  output logic       button_level,
  output logic       press_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       irq_out,
  output logic [1:0] event_code
);

  localparam int unsigned DEB_CYC  = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned LONG_CYC = ms_to_cycles(CLK_HZ, LONG_MS);
  localparam int unsigned REP_CYC  = ms_to_cycles(CLK_HZ, REPEAT_MS);
  localparam int unsigned MAX_CYC  = max3(DEB_CYC, LONG_CYC, REP_CYC);
  localparam int          CW       = $clog2(MAX_CYC + 32'd1);

  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYC - 32'd1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 32'd1);
  localparam logic          REL_LEVEL = (ACTIVE_LOW != 32'd0) ? 1'b1 : 1'b0;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  logic          sync_s;
  logic          p_s;
  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          src_held_q, src_held_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          long_q, long_d;
  logic          irq_q, irq_d;
  logic [1:0]    code_q, code_d;
  logic          ev_valid_s;
  logic [1:0]    ev_code_s;
`ifdef AUTO_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST = CW'(REP_CYC - 32'd1);
  logic [CW-1:0] rep_q, rep_d;
  logic          rep_pulse_q, rep_pulse_d;
`endif

  btn_sync2 #(.RST_VAL(REL_LEVEL)) u_sync (
    .clk_i (clk_clk),
    .rst_i (reset_reset),
    .d_i   (button_in),
    .q_o   (sync_s)
  );

  assign p_s = sync_s ^ REL_LEVEL;

  // The IDLE sample that leaves IDLE is the first of the DEB_CYC stable samples.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    src_held_d = src_held_q;
    press_d    = 1'b0;
    long_d     = 1'b0;
    ev_valid_s = 1'b0;
    ev_code_s  = EV_NONE;
`ifdef AUTO_REPEAT_EN
    rep_d       = rep_q;
    rep_pulse_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (p_s) begin
          state_d = ST_DEB_PRS;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      ST_DEB_PRS: begin
        if (!p_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_LAST) begin
          state_d    = ST_PRESSED;
          cnt_d      = '0;
          hold_d     = '0;
          src_held_d = 1'b0;
          press_d    = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_PRESSED: begin
        hold_d = sat_inc(hold_q);
        if (!p_s) begin
          state_d    = ST_DEB_REL;
          cnt_d      = CW'(1);
          src_held_d = 1'b0;
        end else if (hold_q >= LONG_LAST) begin
          state_d    = ST_HELD;
          long_d     = 1'b1;
          ev_valid_s = 1'b1;
          ev_code_s  = EV_LONG;
`ifdef AUTO_REPEAT_EN
          rep_d = '0;
`endif
        end else begin
          state_d = ST_PRESSED;
        end
      end
      ST_HELD: begin
        hold_d = sat_inc(hold_q);
        if (!p_s) begin
          state_d    = ST_DEB_REL;
          cnt_d      = CW'(1);
          src_held_d = 1'b1;
        end else begin
`ifdef AUTO_REPEAT_EN
          if (rep_q >= REP_LAST) begin
            rep_d       = '0;
            rep_pulse_d = 1'b1;
            ev_valid_s  = 1'b1;
            ev_code_s   = EV_REPEAT;
          end else begin
            rep_d = sat_inc(rep_q);
          end
`else
          state_d = ST_HELD;
`endif
        end
      end
      ST_DEB_REL: begin
        hold_d = sat_inc(hold_q);
        if (p_s) begin
          state_d = src_held_q ? ST_HELD : ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (!src_held_q) begin
            ev_valid_s = 1'b1;
            ev_code_s  = EV_SHORT;
          end else begin
            ev_valid_s = 1'b0;
          end
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  // A new event always beats a same-cycle acknowledge.
  always_comb begin
    irq_d   = irq_q;
    code_d  = code_q;
    level_d = (state_d == ST_PRESSED) || (state_d == ST_HELD) || (state_d == ST_DEB_REL);
    if (ev_valid_s) begin
      irq_d  = 1'b1;
      code_d = ev_code_s;
    end else if (irq_ack && irq_q) begin
      irq_d  = 1'b0;
      code_d = EV_NONE;
    end else begin
      irq_d = irq_q;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hold_q     <= '0;
      src_held_q <= 1'b0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      long_q     <= 1'b0;
      irq_q      <= 1'b0;
      code_q     <= EV_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      src_held_q <= src_held_d;
      level_q    <= level_d;
      press_q    <= press_d;
      long_q     <= long_d;
      irq_q      <= irq_d;
      code_q     <= code_d;
    end
  end

`ifdef AUTO_REPEAT_EN
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      rep_q       <= '0;
      rep_pulse_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_pulse_q <= rep_pulse_d;
    end
  end

  assign repeat_pulse = rep_pulse_q;
`else
  assign repeat_pulse = 1'b0;
`endif

  assign button_level = level_q;
  assign press_pulse  = press_q;
  assign long_pulse   = long_q;
  assign irq_out      = irq_q;
  assign event_code   = code_q;

endmodule

// File: tb/tb_alarm_button_conditioner.sv
// Directed bench for alarm_button_conditioner; pulses are scoreboarded by cycle.
// Define AUTO_REPEAT_EN for both RTL and bench to exercise auto-repeat.
module tb_alarm_button_conditioner;
  import alarm_btn_pkg::*;

  localparam int K_NONE   = 0;
  localparam int K_PRESS  = 1;
  localparam int K_LONG   = 2;
  localparam int K_REPEAT = 3;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  exp_t exp_q[$];

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       ack;
  logic       button_level;
  logic       press_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       irq_out;
  logic [1:0] event_code;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  alarm_button_conditioner #(
    .CLK_HZ      (1000),
    .DEBOUNCE_MS (4),
    .LONG_MS     (20),
    .REPEAT_MS   (5),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk_clk      (clk),
    .reset_reset  (rst),
    .button_in    (btn),
    .irq_ack      (ack),
    .button_level (button_level),
    .press_pulse  (press_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .irq_out      (irq_out),
    .event_code   (event_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int at);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic mon(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("spurious_pulse_kind", kind, K_NONE);
    end else begin
      e = exp_q.pop_front();
      chk("pulse_kind", kind, e.kind);
      chk("pulse_cycle", cyc, e.cyc);
    end
  endtask

  // Every 1-cycle strobe must match the next expected (kind, cycle) entry.
  always @(negedge clk) begin
    if (press_pulse === 1'b1)  mon(K_PRESS);
    if (long_pulse === 1'b1)   mon(K_LONG);
    if (repeat_pulse === 1'b1) mon(K_REPEAT);
  end

  initial begin
    int c;
    rst = 1'b1;
    btn = 1'b0;
    ack = 1'b0;
    repeat (3) @(negedge clk);

    // 1: reset while pressed, press accepted 2 sync + 4 debounce cycles after release
    chk("rst_level", button_level, 0);
    chk("rst_press", press_pulse, 0);
    chk("rst_long", long_pulse, 0);
    chk("rst_repeat", repeat_pulse, 0);
    chk("rst_irq", irq_out, 0);
    chk("rst_code", event_code, EV_NONE);
    c = cyc;
    rst = 1'b0;
    expect_ev(K_PRESS, c + 6);
    wait_to(c + 5);
    chk("t1_level_early", button_level, 0);
    wait_to(c + 6);
    chk("t1_level_on", button_level, 1);
    wait_to(c + 16);
    btn = 1'b1;
    wait_to(c + 21);
    chk("t1_irq_early", irq_out, 0);
    wait_to(c + 22);
    chk("t1_irq", irq_out, 1);
    chk("t1_code", event_code, EV_SHORT);
    chk("t1_level_off", button_level, 0);
    wait_to(c + 30);
    chk("t1_irq_sticky", irq_out, 1);
    chk("t1_code_sticky", event_code, EV_SHORT);
    ack_pulse();
    chk("t1_irq_acked", irq_out, 0);
    chk("t1_code_acked", event_code, EV_NONE);

    // 2: 3-cycle glitch is rejected
    c = cyc;
    btn = 1'b0;
    wait_to(c + 3);
    btn = 1'b1;
    wait_to(c + 15);
    chk("t2_irq", irq_out, 0);
    chk("t2_level", button_level, 0);
    chk("t2_state", dut.state_q, ST_IDLE);

    // 3: short press with a 2-cycle release bounce
    c = cyc;
    btn = 1'b0;
    expect_ev(K_PRESS, c + 6);
    wait_to(c + 16);
    btn = 1'b1;
    wait_to(c + 18);
    btn = 1'b0;
    wait_to(c + 20);
    btn = 1'b1;
    wait_to(c + 22);
    chk("t3_level_bounce", button_level, 1);
    wait_to(c + 25);
    chk("t3_irq_early", irq_out, 0);
    wait_to(c + 26);
    chk("t3_irq", irq_out, 1);
    chk("t3_code", event_code, EV_SHORT);
    ack_pulse();
    chk("t3_irq_acked", irq_out, 0);

    // 4: long press, release produces no short event
    c = cyc;
    btn = 1'b0;
    expect_ev(K_PRESS, c + 6);
    expect_ev(K_LONG, c + 26);
    wait_to(c + 25);
    chk("t4_irq_early", irq_out, 0);
    wait_to(c + 26);
    chk("t4_irq", irq_out, 1);
    chk("t4_code", event_code, EV_LONG);
    wait_to(c + 36);
    btn = 1'b1;
    wait_to(c + 44);
    chk("t4_level_off", button_level, 0);
    chk("t4_code_after_rel", event_code, EV_LONG);

    // 5: short event collides with ack, then lone acks
    c = cyc;
    btn = 1'b0;
    expect_ev(K_PRESS, c + 6);
    wait_to(c + 12);
    btn = 1'b1;
    wait_to(c + 17);
    ack = 1'b1;
    wait_to(c + 18);
    ack = 1'b0;
    chk("t5_collide_irq", irq_out, 1);
    chk("t5_collide_code", event_code, EV_SHORT);
    wait_to(c + 20);
    ack_pulse();
    chk("t5_ack_irq", irq_out, 0);
    chk("t5_ack_code", event_code, EV_NONE);
    wait_to(c + 24);
    ack_pulse();
    chk("t5_idle_ack_irq", irq_out, 0);
    chk("t5_idle_ack_code", event_code, EV_NONE);

    // reset mid-hold, then a still-held button debounces as a fresh press
    c = cyc;
    btn = 1'b0;
    expect_ev(K_PRESS, c + 6);
    wait_to(c + 12);
    rst = 1'b1;
    wait_to(c + 13);
    chk("rh_level", button_level, 0);
    chk("rh_state", dut.state_q, ST_IDLE);
    wait_to(c + 14);
    rst = 1'b0;
    expect_ev(K_PRESS, c + 20);
    wait_to(c + 19);
    chk("rh_level_early", button_level, 0);
    wait_to(c + 24);
    btn = 1'b1;
    wait_to(c + 30);
    chk("rh_irq", irq_out, 1);
    chk("rh_code", event_code, EV_SHORT);
    ack_pulse();

    // 6: 40-cycle hold; repeats only with AUTO_REPEAT_EN
    c = cyc;
    btn = 1'b0;
    expect_ev(K_PRESS, c + 6);
    expect_ev(K_LONG, c + 26);
`ifdef AUTO_REPEAT_EN
    for (int k = 1; k <= 4; k++) expect_ev(K_REPEAT, c + 26 + 5 * k);
`endif
    wait_to(c + 46);
    btn = 1'b1;
    wait_to(c + 56);
    chk("t6_level_off", button_level, 0);
    chk("t6_irq", irq_out, 1);
`ifdef AUTO_REPEAT_EN
    chk("t6_code", event_code, EV_REPEAT);
`else
    chk("t6_code", event_code, EV_LONG);
`endif

    repeat (10) @(negedge clk);
    chk("pending_events", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
